rf_write_arbiter: RTL and testbench

//  Shares the single 128-bit register-file write port between three result sources
//  (0 = even pipe, 1 = odd pipe, 2 = load/store unit).

---
 rtl/rf_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the even pipe,
// the odd pipe and the load/store unit, with a one-entry stallable output stage.
module rf_write_arbiter #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        req_valid,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [ADDR_W-1:0] req_addr2,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [DATA_W-1:0] req_data2,
   output logic [2:0]        req_ready,
   input  logic              wr_stall,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        wr_src
);

   localparam logic [1:0] NO_SRC = 2'b11;

   logic              wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [1:0]        wr_src_q,  wr_src_d;
   logic [1:0]        rr_ptr_q,  rr_ptr_d;

   logic              accept;
   logic [1:0]        win;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] mux_out;

   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Scan from ptr upward with wrap; first valid source wins, NO_SRC if none.
   function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] v);
      logic [1:0] idx;
      logic [1:0] sel;
      sel = NO_SRC;
      idx = ptr;
      for (int k = 0; k < 3; k++) begin
         if (sel == NO_SRC && v[idx]) sel = idx;
         idx = wrap_inc(idx);
      end
      return sel;
   endfunction

   assign accept = ~wr_en_q | ~wr_stall;

   always_comb begin
      win       = NO_SRC;
      req_ready = 3'b000;
      if (accept && !reset) begin
         win = rr_pick(rr_ptr_q, req_valid);
      end
      if (win != NO_SRC) begin
         req_ready = 3'b001 << win;
      end
   end

   always_comb begin
      win_addr = '0;
      case (win)
         2'd0:    win_addr = req_addr0;
         2'd1:    win_addr = req_addr1;
         2'd2:    win_addr = req_addr2;
         default: win_addr = '0;
      endcase
   end

   Mux3to1 #(.dataWidth(DATA_W)) u_data_mux (
      .sel_i (win),
      .in0_i (req_data0),
      .in1_i (req_data1),
      .in2_i (req_data2),
      .out_o (mux_out)
   );

   always_comb begin
      wr_en_d   = wr_en_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      rr_ptr_d  = rr_ptr_q;
      if (accept) begin
         if (win != NO_SRC) begin
            wr_en_d   = 1'b1;
            wr_addr_d = win_addr;
            wr_data_d = mux_out;
            wr_src_d  = win;
            rr_ptr_d  = wrap_inc(win);
         end else begin
            // Idle slot: address and data keep their last values.
            wr_en_d  = 1'b0;
            wr_src_d = NO_SRC;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_src_q  <= NO_SRC;
         rr_ptr_q  <= 2'd0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_src  = wr_src_q;

endmodule

// Three-way data selector; floats when no input is selected (sel = 2'b11).
module Mux3to1 #(
   parameter int dataWidth = 128
) (
   input  logic [1:0]           sel_i,
   input  logic [dataWidth-1:0] in0_i,
   input  logic [dataWidth-1:0] in1_i,
   input  logic [dataWidth-1:0] in2_i,
   output logic [dataWidth-1:0] out_o
);

   assign out_o = (sel_i == 2'b00) ? in0_i :
                  (sel_i == 2'b01) ? in1_i :
                  (sel_i == 2'b10) ? in2_i : {dataWidth{1'bz}};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed arbitration/stall/reset steps, then random
// traffic checked by a scoreboard, one-hot ready monitor and fairness monitor.
module tb_rf_write_arbiter;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 7;

   typedef logic [143:0] cv_t;
   typedef struct packed {
      logic [1:0]        src;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        req_valid;
   logic [ADDR_W-1:0] req_addr0, req_addr1, req_addr2;
   logic [DATA_W-1:0] req_data0, req_data1, req_data2;
   logic [2:0]        req_ready;
   logic              wr_stall;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        wr_src;

   int        tests = 0;
   int        fails = 0;
   int        writes = 0;
   int        wait_cnt [3];
   logic [2:0] xfer_now = 3'b000;
   wr_t       sb [$];

   rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr0 (req_addr0),
      .req_addr1 (req_addr1),
      .req_addr2 (req_addr2),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_data2 (req_data2),
      .req_ready (req_ready),
      .wr_stall  (wr_stall),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_src    (wr_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input cv_t obs, input cv_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic wr_t src_item(input logic [1:0] i);
      wr_t w;
      w.src = i;
      case (i)
         2'd0:    begin w.addr = req_addr0; w.data = req_data0; end
         2'd1:    begin w.addr = req_addr1; w.data = req_data1; end
         default: begin w.addr = req_addr2; w.data = req_data2; end
      endcase
      return w;
   endfunction

   task automatic set_src(input logic [1:0] i, input logic v,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[i] = v;
      case (i)
         2'd0:    begin req_addr0 = a; req_data0 = d; end
         2'd1:    begin req_addr1 = a; req_data1 = d; end
         default: begin req_addr2 = a; req_data2 = d; end
      endcase
   endtask

   // Mid-cycle monitor: retire the presented write, then log the transfer about to happen.
   initial begin
      logic [2:0] x;
      wr_t        got;
      wr_t        exp_w;
      for (int i = 0; i < 3; i++) wait_cnt[i[1:0]] = 0;
      forever begin
         mid();
         if (reset) begin
            sb.delete();
            xfer_now = 3'b000;
            for (int i = 0; i < 3; i++) wait_cnt[i[1:0]] = 0;
         end else begin
            x = req_valid & req_ready;
            chk("ready_onehot0", cv_t'($onehot0(req_ready)), cv_t'(1));
            if (!wr_en) chk("idle_src", cv_t'(wr_src), cv_t'(2'b11));
            if (wr_en && !wr_stall) begin
               writes++;
               chk("sb_nonempty", cv_t'(sb.size() != 0), cv_t'(1));
               if (sb.size() != 0) begin
                  exp_w = sb.pop_front();
                  got   = {wr_src, wr_addr, wr_data};
                  chk("sb_write", cv_t'(got), cv_t'(exp_w));
               end
            end
            for (int i = 0; i < 3; i++) begin
               if (x[i[1:0]]) sb.push_back(src_item(i[1:0]));
               if (!req_valid[i[1:0]] || x[i[1:0]]) begin
                  wait_cnt[i[1:0]] = 0;
               end else if (x != 3'b000) begin
                  wait_cnt[i[1:0]]++;
                  chk("fair_wait", cv_t'(wait_cnt[i[1:0]] <= 2), cv_t'(1));
               end
            end
            xfer_now = x;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] exp_r;
      logic [1:0] prev;
      reset = 1'b1;
      req_valid = 3'b111;
      wr_stall = 1'b0;
      req_addr0 = '0; req_addr1 = '0; req_addr2 = '0;
      req_data0 = '0; req_data1 = '0; req_data2 = '0;

      // Reset state, with all sources requesting
      mid();
      chk("rst_ready", cv_t'(req_ready), cv_t'(3'b000));
      chk("rst_wr_en", cv_t'(wr_en), cv_t'(0));
      chk("rst_wr_addr", cv_t'(wr_addr), cv_t'(0));
      chk("rst_wr_data", cv_t'(wr_data), cv_t'(0));
      chk("rst_wr_src", cv_t'(wr_src), cv_t'(2'b11));
      cyc();
      reset = 1'b0;
      req_valid = 3'b000;

      // Single request from source 1
      set_src(2'd1, 1'b1, 7'd5, 128'hA5);
      mid();
      chk("t1_ready", cv_t'(req_ready), cv_t'(3'b010));
      cyc();
      req_valid = 3'b000;
      mid();
      chk("t1_wr_en", cv_t'(wr_en), cv_t'(1));
      chk("t1_wr_addr", cv_t'(wr_addr), cv_t'(7'd5));
      chk("t1_wr_data", cv_t'(wr_data), cv_t'(128'hA5));
      chk("t1_wr_src", cv_t'(wr_src), cv_t'(2'd1));
      cyc();

      // Pointer now at 2: with everyone valid, source 2 wins first
      set_src(2'd0, 1'b1, 7'd10, 128'h1000);
      set_src(2'd1, 1'b1, 7'd11, 128'h1111);
      set_src(2'd2, 1'b1, 7'd12, 128'h2222);
      mid();
      chk("t1_ptr2_ready", cv_t'(req_ready), cv_t'(3'b100));
      cyc();

      // Continuous requests: 0,1,2,0,1,2
      prev = 2'd2;
      for (int k = 0; k < 6; k++) begin
         mid();
         exp_r = 3'b001 << (k % 3);
         chk("t2_ready", cv_t'(req_ready), cv_t'(exp_r));
         chk("t2_src", cv_t'(wr_src), cv_t'(prev));
         prev = 2'(k % 3);
         cyc();
      end
      req_valid = 3'b000;
      mid();
      chk("t2_src_last", cv_t'(wr_src), cv_t'(2'd2));
      cyc();

      // Stall holds the source-0 write for 3 cycles while source 1 waits
      set_src(2'd0, 1'b1, 7'd33, 128'hC0C0);
      mid();
      chk("t3_ready0", cv_t'(req_ready), cv_t'(3'b001));
      cyc();
      req_valid = 3'b000;
      set_src(2'd1, 1'b1, 7'd9, 128'hD1D1);
      wr_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("t3_stall_ready", cv_t'(req_ready), cv_t'(3'b000));
         chk("t3_hold", cv_t'({wr_en, wr_src, wr_addr, wr_data}),
             cv_t'({1'b1, 2'd0, 7'd33, 128'hC0C0}));
         cyc();
      end
      wr_stall = 1'b0;
      mid();
      chk("t3_release_ready", cv_t'(req_ready), cv_t'(3'b010));
      chk("t3_release_src", cv_t'(wr_src), cv_t'(2'd0));
      cyc();
      req_valid = 3'b000;
      set_src(2'd2, 1'b1, 7'd44, 128'hE2E2);
      mid();
      chk("t3_src1_write", cv_t'({wr_en, wr_src, wr_addr, wr_data}),
          cv_t'({1'b1, 2'd1, 7'd9, 128'hD1D1}));
      chk("t3_ptr2_ready", cv_t'(req_ready), cv_t'(3'b100));
      cyc();
      req_valid = 3'b000;
      mid();
      cyc();

      // Source 2 alone from pointer 0, then pointer wraps to 0
      set_src(2'd2, 1'b1, 7'd50, 128'hF00D);
      mid();
      chk("t4_ready", cv_t'(req_ready), cv_t'(3'b100));
      cyc();
      req_valid = 3'b000;
      set_src(2'd0, 1'b1, 7'd51, 128'h5151);
      set_src(2'd1, 1'b1, 7'd52, 128'h5252);
      mid();
      chk("t4_src", cv_t'(wr_src), cv_t'(2'd2));
      chk("t4_wrap_ready", cv_t'(req_ready), cv_t'(3'b001));
      cyc();
      req_valid[0] = 1'b0;
      mid();
      chk("t4_next_ready", cv_t'(req_ready), cv_t'(3'b010));
      cyc();
      req_valid = 3'b000;
      mid();
      cyc();

      // Reset pulsed with a write in flight and sources valid
      req_valid = 3'b111;
      mid();
      cyc();
      chk("t5_pre_wr_en", cv_t'(wr_en), cv_t'(1));
      reset = 1'b1;
      #1;
      chk("t5_rst_wr_en", cv_t'(wr_en), cv_t'(0));
      chk("t5_rst_wr_src", cv_t'(wr_src), cv_t'(2'b11));
      chk("t5_rst_ready", cv_t'(req_ready), cv_t'(3'b000));
      mid();
      chk("t5_rst_ready_mid", cv_t'(req_ready), cv_t'(3'b000));
      cyc();
      reset = 1'b0;
      req_valid = 3'b110;
      mid();
      chk("t5_first_grant", cv_t'(req_ready), cv_t'(3'b010));
      cyc();
      req_valid = 3'b100;
      mid();
      chk("t5_second_grant", cv_t'(req_ready), cv_t'(3'b100));
      cyc();
      req_valid = 3'b000;

      // Random traffic; sources hold each request until it transfers
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!req_valid[i[1:0]] || xfer_now[i[1:0]]) begin
               set_src(i[1:0], ($urandom_range(0, 2) != 0), 7'($urandom()),
                       {$urandom(), $urandom(), $urandom(), $urandom()});
            end
         end
         wr_stall = ($urandom_range(0, 3) == 0);
         cyc();
      end
      req_valid = 3'b000;
      wr_stall = 1'b0;
      repeat (4) cyc();
      mid();
      chk("drain_sb_empty", cv_t'(sb.size()), cv_t'(0));
      chk("writes_seen", cv_t'(writes > 1000), cv_t'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
